mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive cycles an instruction request may lose to data before it is granted priority (range 1..15).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-004 Port: inst_req  input  1  instruction-fetch request; held high and stable until inst_ready.
REQ-005 Port: inst_addr  input  32  fetch byte address.
REQ-006 Port: inst_rdata  output  32  fetched word; valid only while inst_ready=1.
REQ-007 Port: inst_ready  output  1  one-cycle completion pulse for the fetch port.
REQ-008 Port: data_req  input  1  data-access request; held high and stable until data_ready.
REQ-009 Port: data_wen  input  4  byte write enables; 0000 = read.
REQ-010 Port: data_addr  input  32  data byte address.
REQ-011 Port: data_wdata  input  32  store data.
REQ-012 Port: data_rdata  output  32  load word; valid only while data_ready=1 and the access was a read.
REQ-013 Port: data_ready  output  1  one-cycle completion pulse for the data port.
REQ-014 Port: ram_en  output  1  single-port RAM enable.
REQ-015 Port: ram_wen  output  4  RAM byte write enables.
REQ-016 Port: ram_addr  output  32  RAM address.
REQ-017 Port: ram_wdata  output  32  RAM write data.
REQ-018 Port: ram_rdata  input  32  RAM read data; valid the cycle after an enabled read edge (1-cycle latency).

Function
REQ-019 FSM states IDLE, WAIT_I, WAIT_D; one RAM access in flight at most.
REQ-020 IDLE, no request: ram_en=0, ram_wen=0000, ram_addr=0, ram_wdata=0, stay IDLE.
REQ-021 IDLE, grant data: ram_en=1, ram_wen=data_wen, ram_addr=data_addr, ram_wdata=data_wdata (combinational); next state WAIT_D.
REQ-022 IDLE, grant instruction: ram_en=1, ram_wen=0000, ram_addr=inst_addr, ram_wdata=0; next state WAIT_I.
REQ-023 Grant rule in IDLE: only one request -> grant it; both -> grant data unless starve_cnt >= STARVE_LIMIT, in which case grant instruction.
REQ-024 starve_cnt (4-bit): increments, saturating at 15, on each IDLE edge where inst_req=1 and data is granted; clears on every instruction grant; otherwise holds.
REQ-025 WAIT_I: inst_ready=1, inst_rdata=ram_rdata, ram_en=0; next state IDLE unconditionally.
REQ-026 WAIT_D: data_ready=1, data_rdata=ram_rdata, ram_en=0; next state IDLE; a write also pulses data_ready.
REQ-027 Latency: request seen in IDLE completes with ready on the following cycle; throughput 1 access per 2 cycles per port.
REQ-028 Requests are never issued from WAIT_I/WAIT_D; a requester still holding req in its ready cycle is not re-served.
REQ-029 Outside their ready cycle inst_rdata and data_rdata drive 0; inst_ready and data_ready never high together.
REQ-030 A request dropped before its grant is a protocol violation; behaviour then is don't-care except that the FSM returns to IDLE within 2 cycles.

Reset
REQ-031 rst=0 forces immediately, regardless of clk: state IDLE, starve_cnt=0, inst_ready=0, data_ready=0, ram_en=0, ram_wen=0000.
REQ-032 Reset during WAIT_I/WAIT_D abandons the access without a ready pulse; requester re-issues after rst deasserts; the first edge after deassertion evaluates IDLE normally.

Verification
REQ-033 Fetch only: inst_req=1, inst_addr=0x100, RAM word 0x2402000A -> ram_en=1 addr 0x100 in cycle 0; cycle 1 inst_ready=1, inst_rdata=0x2402000A.
REQ-034 Store then load: data_wen=1111, addr 0x40, wdata 0xDEADBEEF -> data_ready next cycle; then read 0x40 -> data_rdata=0xDEADBEEF.
REQ-035 Contention, STARVE_LIMIT=4: both req held, data re-requests every IDLE -> data granted 4 times, 5th grant goes to instruction, starve_cnt back to 0.
REQ-036 Byte store: data_wen=0010 to 0x40 holding 0xDEADBEEF with wdata 0x00005500 -> subsequent read returns 0xDEAD55EF.
REQ-037 Async reset in WAIT_D (rst low mid-cycle) -> data_ready=0 and ram_en=0 before next clk edge; after release, re-issued request completes in 2 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter in front of one single-port RAM with 1-cycle read latency
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset (0 = reset asserted)
//   inst_*      fetch port: inst_req/inst_addr in, inst_ready/inst_rdata out
//   data_*      data port: data_req/data_wen/data_addr/data_wdata in, data_ready/data_rdata out
//   ram_*       RAM side: ram_en/ram_wen/ram_addr/ram_wdata out, ram_rdata in
//
// Data wins contention until the fetch side has lost STARVE_LIMIT times in a row,
// after which the fetch side is granted once and the loss counter clears.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ready,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ready,
    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;
    state_t      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        in_idle, grant_i, grant_d;
    always_comb begin
        // Gating with rst keeps the RAM port quiet while reset is held, even though the FSM sits in IDLE.
        in_idle      = (state_q == IDLE) && rst;
        grant_i      = in_idle && inst_req && (!data_req || starve_cnt_q >= 4'(STARVE_LIMIT));
        grant_d      = in_idle && data_req && !grant_i;
        state_d      = grant_i ? WAIT_I : grant_d ? WAIT_D : IDLE;
        starve_cnt_d = grant_i ? 4'd0
                     : (grant_d && inst_req && starve_cnt_q != 4'hf) ? starve_cnt_q + 4'd1
                     : starve_cnt_q;
        ram_en       = grant_i || grant_d;
        ram_wen      = grant_d ? data_wen : 4'b0000;
        ram_addr     = grant_d ? data_addr : grant_i ? inst_addr : 32'h0;
        ram_wdata    = grant_d ? data_wdata : 32'h0;
        // Ready pulses decode straight from the state flop, so async reset clears them immediately.
        inst_ready   = (state_q == WAIT_I);
        data_ready   = (state_q == WAIT_D);
        inst_rdata   = inst_ready ? ram_rdata : 32'h0;
        data_rdata   = data_ready ? ram_rdata : 32'h0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a behavioural 1-cycle-latency RAM
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] mem [0:255];
    logic [31:0] inst_q[$];
    logic [31:0] data_q[$];
    int          checks = 0;
    int          errors = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_ready(data_ready),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) mem[64] <= 32'h2402000A;
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr[9:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic inst_fetch(input logic [31:0] a, input logic [31:0] exp_rd);
        @(negedge clk);
        inst_req  = 1'b1;
        inst_addr = a;
        inst_q.push_back(exp_rd);
        #1;
        chk("i_ram_en", ram_en, 1);
        chk("i_ram_addr", ram_addr, a);
        chk("i_ram_wen", ram_wen, 0);
        @(negedge clk);
        chk("i_ready", inst_ready, 1);
        chk("i_d_ready_excl", data_ready, 0);
        chk("i_no_reissue", ram_en, 0);
        chk("i_rdata", inst_rdata, inst_q.pop_front());
        inst_req = 1'b0;
    endtask

    task automatic data_access(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] exp_rd);
        @(negedge clk);
        data_req   = 1'b1;
        data_wen   = wen;
        data_addr  = a;
        data_wdata = wd;
        if (wen == 4'b0000) data_q.push_back(exp_rd);
        #1;
        chk("d_ram_en", ram_en, 1);
        chk("d_ram_addr", ram_addr, a);
        chk("d_ram_wen", ram_wen, wen);
        chk("d_ram_wdata", ram_wdata, wd);
        @(negedge clk);
        chk("d_ready", data_ready, 1);
        chk("d_i_ready_excl", inst_ready, 0);
        chk("d_no_reissue", ram_en, 0);
        if (wen == 4'b0000) chk("d_rdata", data_rdata, data_q.pop_front());
        data_req = 1'b0;
    endtask

    initial begin
        inst_req = 1'b1;
        #3;
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_wen", ram_wen, 0);
        chk("rst_inst_ready", inst_ready, 0);
        chk("rst_data_ready", data_ready, 0);
        inst_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle_ram_en", ram_en, 0);
        chk("idle_ram_addr", ram_addr, 0);
        chk("idle_ram_wdata", ram_wdata, 0);
        chk("idle_inst_rdata", inst_rdata, 0);
        chk("idle_data_rdata", data_rdata, 0);

        inst_fetch(32'h100, 32'h2402000A);
        data_access(4'b1111, 32'h40, 32'hDEADBEEF, 32'h0);
        data_access(4'b0000, 32'h40, 32'h0, 32'hDEADBEEF);
        data_access(4'b0010, 32'h40, 32'h00005500, 32'h0);
        data_access(4'b0000, 32'h40, 32'h0, 32'hDEAD55EF);

        // contention: data wins four times, then the fetch is forced through
        @(negedge clk);
        inst_req  = 1'b1;
        inst_addr = 32'h100;
        data_req  = 1'b1;
        data_wen  = 4'b0000;
        data_addr = 32'h40;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("c_grant_data", ram_addr, 32'h40);
            data_q.push_back(32'hDEAD55EF);
            @(negedge clk);
            chk("c_d_ready", data_ready, 1);
            chk("c_i_waiting", inst_ready, 0);
            chk("c_d_rdata", data_rdata, data_q.pop_front());
            @(negedge clk);
        end
        #1;
        chk("c_grant_inst_addr", ram_addr, 32'h100);
        chk("c_grant_inst_wen", ram_wen, 0);
        inst_q.push_back(32'h2402000A);
        @(negedge clk);
        chk("c_i_ready", inst_ready, 1);
        chk("c_d_not_ready", data_ready, 0);
        chk("c_i_rdata", inst_rdata, inst_q.pop_front());
        @(negedge clk);
        #1;
        chk("c_cnt_cleared_grant_data", ram_addr, 32'h40);
        inst_req = 1'b0;
        data_q.push_back(32'hDEAD55EF);
        @(negedge clk);
        chk("c_d_ready_after", data_ready, 1);
        chk("c_d_rdata_after", data_rdata, data_q.pop_front());
        data_req = 1'b0;

        // async reset while waiting on a data read
        @(negedge clk);
        data_req  = 1'b1;
        data_wen  = 4'b0000;
        data_addr = 32'h40;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_data_ready", data_ready, 0);
        chk("ar_ram_en", ram_en, 0);
        chk("ar_data_rdata", data_rdata, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_reissue_en", ram_en, 1);
        chk("ar_reissue_addr", ram_addr, 32'h40);
        data_q.push_back(32'hDEAD55EF);
        @(negedge clk);
        chk("ar_d_ready", data_ready, 1);
        chk("ar_d_rdata", data_rdata, data_q.pop_front());
        data_req = 1'b0;
        @(negedge clk);
        chk("sb_empty", 32'(inst_q.size() + data_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
